// File: rtl/cfm_pkg.sv
// Constants and helpers shared by the conflict-free bank map (write side)
// and its read-side counterpart.
package cfm_pkg;

    localparam int NUM_BANKS = 16;
    localparam int BANK_AW   = 6;
    localparam int LOG_AW    = 10;
    localparam int BANK_W    = 4;

    localparam logic [BANK_AW-1:0] LAST_ROW = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } rd_state_e;

    // Parity of the row index: 1 means the two 8-bank halves are swapped.
    function automatic logic cfm_swap(input logic [BANK_AW-1:0] row);
        return ^row;
    endfunction

endpackage

// File: rtl/cfm_row_fifo.sv
// Two-entry synchronous FIFO holding reordered rows plus their row tag.
// The head entry is visible combinationally so a beat can be offered the cycle it lands.
module cfm_row_fifo #(
    parameter int WIDTH = 262
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem_reg [2];
    logic             wr_ptr_reg;
    logic             rd_ptr_reg;
    logic [1:0]       count_reg;
    logic             push;
    logic             pop;

    assign empty   = (count_reg == 2'd0);
    assign count   = count_reg;
    assign push    = wr_en && (count_reg != 2'd2);
    assign pop     = rd_en && !empty;
    assign rd_data = mem_reg[rd_ptr_reg];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_reg[0] <= '0;
            mem_reg[1] <= '0;
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push) begin
                mem_reg[wr_ptr_reg] <= wr_data;
                wr_ptr_reg          <= !wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= !rd_ptr_reg;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/conflict_free_bank_reader.sv
// Streams a 1024-coefficient polynomial out of 16 conflict-free banks in
// natural order, one row per beat, under valid/ready with credit-based read issue.
module conflict_free_bank_reader
    import cfm_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic                          bank_rd_en,
    output logic [BANK_AW-1:0]            bank_rd_addr,
    input  logic [NUM_BANKS*DATA_WIDTH-1:0] bank_rd_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_BANKS*DATA_WIDTH-1:0] out_data,
    output logic [BANK_AW-1:0]            out_row,
    output logic                          out_last
);

    localparam int ROW_W   = NUM_BANKS * DATA_WIDTH;
    localparam int ENTRY_W = ROW_W + BANK_AW;
    localparam int HALF    = NUM_BANKS / 2;

    rd_state_e          state_reg, state_next;
    logic [BANK_AW-1:0] row_cnt_reg, row_cnt_next;
    logic               inflight_reg;
    logic [BANK_AW-1:0] inflight_row_reg;
    logic               done_reg, done_next;

    logic               issue;
    logic               pop;
    logic               swap;
    logic [2:0]         credit_used;
    logic [ROW_W-1:0]   reordered;
    logic [ENTRY_W-1:0] fifo_rd_data;
    logic               fifo_empty;
    logic [1:0]         fifo_count;

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign {out_row, out_data} = fifo_rd_data;
    assign out_last  = out_valid && (out_row == LAST_ROW);

    // Rows held in the FIFO plus the one in flight; a pop this cycle frees a slot.
    assign credit_used = {1'b0, fifo_count} + {2'b00, inflight_reg};
    assign issue       = (state_reg == ST_RUN) && (credit_used < (3'd2 + {2'b00, pop}));

    assign busy         = (state_reg != ST_IDLE);
    assign done         = done_reg;
    assign bank_rd_en   = issue;
    assign bank_rd_addr = row_cnt_reg;

    assign swap = cfm_swap(inflight_row_reg);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BANKS; gi++) begin : g_lane
            assign reordered[gi*DATA_WIDTH +: DATA_WIDTH] = swap
                ? bank_rd_data[(gi ^ HALF)*DATA_WIDTH +: DATA_WIDTH]
                : bank_rd_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    cfm_row_fifo #(
        .WIDTH (ENTRY_W)
    ) u_row_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (inflight_reg),
        .wr_data ({inflight_row_reg, reordered}),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_comb begin
        state_next   = state_reg;
        row_cnt_next = row_cnt_reg;
        done_next    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                // A start coinciding with the done pulse belongs to the old run.
                if (start && !done_reg) begin
                    state_next   = ST_RUN;
                    row_cnt_next = '0;
                end
            end
            ST_RUN: begin
                if (issue) begin
                    row_cnt_next = row_cnt_reg + 1'b1;
                    if (row_cnt_reg == LAST_ROW) begin
                        state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Row 63 at the head means every earlier row is gone and nothing is in flight.
                if (pop && out_last) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= ST_IDLE;
            row_cnt_reg      <= '0;
            inflight_reg     <= 1'b0;
            inflight_row_reg <= '0;
            done_reg         <= 1'b0;
        end else begin
            state_reg    <= state_next;
            row_cnt_reg  <= row_cnt_next;
            done_reg     <= done_next;
            inflight_reg <= issue;
            if (issue) begin
                inflight_row_reg <= row_cnt_reg;
            end
        end
    end

endmodule

// File: tb/tb_conflict_free_bank_reader.sv
// Self-checking bench: banks are preloaded through the forward address map and
// every beat is compared against the logical coefficient array.
module tb_conflict_free_bank_reader;

    localparam int DW    = 16;
    localparam int ROW_W = 16 * DW;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             busy;
    logic             done;
    logic             bank_rd_en;
    logic [5:0]       bank_rd_addr;
    logic [ROW_W-1:0] bank_rd_data;
    logic             out_valid;
    logic             out_ready;
    logic [ROW_W-1:0] out_data;
    logic [5:0]       out_row;
    logic             out_last;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] log_mem  [1024];
    logic [DW-1:0] bank_mem [16][64];

    conflict_free_bank_reader #(
        .DATA_WIDTH (DW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .bank_rd_en   (bank_rd_en),
        .bank_rd_addr (bank_rd_addr),
        .bank_rd_data (bank_rd_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_row      (out_row),
        .out_last     (out_last)
    );

    always #5 clk = ~clk;

    // Bank RAM model: one-cycle registered read.
    always @(posedge clk) begin
        if (bank_rd_en) begin
            for (int b = 0; b < 16; b++) begin
                bank_rd_data[b*DW +: DW] <= bank_mem[b][bank_rd_addr];
            end
        end
    end

    task automatic check(input string tag, input logic [ROW_W-1:0] obs, input logic [ROW_W-1:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Fill the logical array and place each coefficient with the forward map.
    task automatic load(input bit rnd);
        logic [9:0] av;
        logic       p;
        logic [3:0] bk;
        for (int a = 0; a < 1024; a++) begin
            av = 10'(a);
            p  = ^av[9:4];
            bk = av[3:0] ^ {p, 3'b000};
            log_mem[a] = rnd ? DW'($urandom) : DW'(a);
            bank_mem[bk][av[9:4]] = log_mem[a];
        end
    endtask

    function automatic logic [ROW_W-1:0] exp_row(input int r);
        logic [ROW_W-1:0] v;
        v = '0;
        for (int j = 0; j < 16; j++) begin
            v[j*DW +: DW] = log_mem[r*16 + j];
        end
        return v;
    endfunction

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"},      ROW_W'(busy), '0);
        check({tag, "_done"},      ROW_W'(done), '0);
        check({tag, "_rd_en"},     ROW_W'(bank_rd_en), '0);
        check({tag, "_rd_addr"},   ROW_W'(bank_rd_addr), '0);
        check({tag, "_out_valid"}, ROW_W'(out_valid), '0);
        check({tag, "_out_data"},  out_data, '0);
        check({tag, "_out_row"},   ROW_W'(out_row), '0);
        check({tag, "_out_last"},  ROW_W'(out_last), '0);
    endtask

    // One complete readout with optional stall, start pokes, exact timing and parity probes.
    task automatic run_readout(input int ready_pct, input int stall_row, input int stall_len,
                               input bit poke_start, input bit exact, input bit parity_chk);
        int cyc, issued, popped, next_row, last_hs, done_cnt, stall_left, stall_reads;
        bit stall_armed, in_stall, hs, finished;
        logic [ROW_W-1:0] held;
        issued      = 0;
        popped      = 0;
        next_row    = 0;
        last_hs     = 1000000;
        done_cnt    = 0;
        stall_left  = 0;
        stall_reads = 0;
        stall_armed = (stall_len > 0);
        finished    = 1'b0;
        held        = '0;
        start       = 1'b1;
        out_ready   = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (cyc = 1; cyc < 3000 && !finished; cyc++) begin
            start    = 1'b0;
            in_stall = 1'b0;
            if (poke_start && (cyc == 10 || cyc == 40 || cyc == last_hs + 1)) start = 1'b1;
            if (stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
                in_stall = 1'b1;
            end else if (stall_armed && out_valid && (int'(out_row) == stall_row)) begin
                stall_armed = 1'b0;
                stall_left  = stall_len - 1;
                out_ready   = 1'b0;
                in_stall    = 1'b1;
                held        = out_data;
                check("stall_head_data", held, exp_row(stall_row));
            end else begin
                out_ready = (int'($urandom_range(99)) < ready_pct);
            end
            #1;
            if (cyc == 1) begin
                check("busy_rise", ROW_W'(busy), ROW_W'(1));
                check("first_issue", ROW_W'({bank_rd_en, bank_rd_addr}), ROW_W'({1'b1, 6'd0}));
            end
            if (bank_rd_en) begin
                check("rd_addr", ROW_W'(bank_rd_addr), ROW_W'(issued));
                issued++;
                if (in_stall) stall_reads++;
            end
            hs = out_valid && out_ready;
            if (hs) popped++;
            check("outstanding_le2", ROW_W'(issued - popped <= 2), ROW_W'(1));
            if (in_stall) begin
                check("stall_valid", ROW_W'(out_valid), ROW_W'(1));
                check("stall_row", ROW_W'(out_row), ROW_W'(stall_row));
                check("stall_hold", out_data, held);
            end
            if (hs) begin
                check("beat_row", ROW_W'(out_row), ROW_W'(next_row));
                check("beat_data", out_data, exp_row(next_row));
                check("beat_last", ROW_W'(out_last), ROW_W'(next_row == 63));
                if (exact) check("beat_cycle", ROW_W'(cyc), ROW_W'(3 + next_row));
                if (parity_chk && next_row == 1) begin
                    check("par_r1_lane0", ROW_W'(out_data[0 +: DW]), ROW_W'(16));
                    check("par_r1_lane8", ROW_W'(out_data[8*DW +: DW]), ROW_W'(24));
                end
                if (parity_chk && next_row == 3) begin
                    check("par_r3_lane0", ROW_W'(out_data[0 +: DW]), ROW_W'(48));
                end
                if (next_row == 63) last_hs = cyc;
                next_row++;
            end
            if (done) begin
                done_cnt++;
                check("done_cycle", ROW_W'(cyc), ROW_W'(last_hs + 1));
                check("busy_at_done", ROW_W'(busy), '0);
            end
            if (cyc > last_hs + 1) begin
                check("idle_busy", ROW_W'(busy), '0);
                check("idle_rd_en", ROW_W'(bank_rd_en), '0);
            end
            if (cyc == last_hs + 3) begin
                finished = 1'b1;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        start = 1'b0;
        check("readout_finished", ROW_W'(finished), ROW_W'(1));
        check("done_count", ROW_W'(done_cnt), ROW_W'(1));
        check("row_count", ROW_W'(next_row), ROW_W'(64));
        if (exact) check("done_at_67", ROW_W'(last_hs + 1), ROW_W'(67));
        if (stall_len > 0) begin
            check("stall_seen", ROW_W'(stall_armed), '0);
            check("stall_reads_le2", ROW_W'(stall_reads <= 2), ROW_W'(1));
        end
    endtask

    initial begin
        bit found;
        rst       = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        load(1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_after_reset", ROW_W'(busy), '0);

        $display("step: full readout, ready held high");
        run_readout(100, 0, 0, 1'b0, 1'b1, 1'b1);

        $display("step: backpressure 10 cycles at beat 5");
        run_readout(100, 5, 10, 1'b0, 1'b0, 1'b0);

        $display("step: random backpressure 30%% ready, random data");
        load(1'b1);
        run_readout(30, 0, 0, 1'b0, 1'b0, 1'b0);

        $display("step: start pulses while busy and on done");
        run_readout(100, 0, 0, 1'b1, 1'b1, 1'b0);

        $display("step: reset while row 30 pending");
        start     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (bank_rd_en && bank_rd_addr == 6'd30) begin
                found = 1'b1;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        check("reach_row30", ROW_W'(found), ROW_W'(1));
        rst = 1'b1;
        #1;
        check_zero_outputs("midrun_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("post_reset_no_beat", ROW_W'({out_valid, busy, bank_rd_en}), '0);
        end

        $display("step: restart after reset");
        run_readout(100, 0, 0, 1'b0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
